// File: rtl/axil_master.sv
// axil_master: single-outstanding AXI4-Lite initiator.
// Turns one local command into one AXI4-Lite read or write. The result comes
// back on a valid/ready response port.
// Optional build macro: AXIL_MASTER_ERR_CNT_EN adds a saturating error counter
// (err_count) with a synchronous clear input (err_clr).
module axil_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  // local command port
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
  // local response port
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_write,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,
  // AXI AW channel
  output logic [ADDR_WIDTH-1:0]     m_awaddr,
  output logic [2:0]                m_awprot,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  // AXI W channel
  output logic [DATA_WIDTH-1:0]     m_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_wstrb,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  // AXI B channel
  input  logic [1:0]                m_bresp,
  input  logic                      m_bvalid,
  output logic                      m_bready,
  // AXI AR channel
  output logic [ADDR_WIDTH-1:0]     m_araddr,
  output logic [2:0]                m_arprot,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  // AXI R channel
  input  logic [DATA_WIDTH-1:0]     m_rdata,
  input  logic [1:0]                m_rresp,
  input  logic                      m_rvalid,
  output logic                      m_rready
`ifdef AXIL_MASTER_ERR_CNT_EN
  ,
  output logic [7:0]                err_count,
  input  logic                      err_clr
`endif
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t                  state_q,     state_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q,    awaddr_d;
  logic [ADDR_WIDTH-1:0]   araddr_q,    araddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q,     wdata_d;
  logic [STRB_WIDTH-1:0]   wstrb_q,     wstrb_d;
  logic                    awvalid_q,   awvalid_d;
  logic                    wvalid_q,    wvalid_d;
  logic                    arvalid_q,   arvalid_d;
  logic                    rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]              rsp_resp_q,  rsp_resp_d;

  // Every valid is a flop and every ready output decodes only the state
  // register, so no *ready input reaches a *valid output combinationally.
  assign cmd_ready = (state_q == IDLE) && !rst;
  assign rsp_valid = (state_q == RESP);
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;

  assign m_awaddr  = awaddr_q;
  assign m_awprot  = '0;
  assign m_awvalid = awvalid_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;
  assign m_wvalid  = wvalid_q;
  assign m_bready  = (state_q == WR_RESP);
  assign m_araddr  = araddr_q;
  assign m_arprot  = '0;
  assign m_arvalid = arvalid_q;
  assign m_rready  = (state_q == RD_DATA);

  // Next-state and channel control for the one in-flight transaction.
  always_comb begin
    state_d     = state_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_write) begin
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_REQ;
          end else begin
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
            state_d   = RD_REQ;
          end
        end
      end

      WR_REQ: begin
        if (awvalid_q && m_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_wready)   wvalid_d  = 1'b0;
        // A channel counts as done if it already handshook or does so now.
        if ((!awvalid_q || m_awready) && (!wvalid_q || m_wready)) begin
          state_d = WR_RESP;
        end
      end

      WR_RESP: begin
        if (m_bvalid) begin
          rsp_resp_d  = m_bresp;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          state_d     = RESP;
        end
      end

      RD_REQ: begin
        if (m_arready) begin
          arvalid_d = 1'b0;
          state_d   = RD_DATA;
        end
      end

      RD_DATA: begin
        if (m_rvalid) begin
          rsp_resp_d  = m_rresp;
          rsp_write_d = 1'b0;
          rsp_rdata_d = m_rdata;
          state_d     = RESP;
        end
      end

      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any transaction immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

`ifdef AXIL_MASTER_ERR_CNT_EN
  logic       resp_err;
  logic [7:0] err_count_q, err_count_d;

  assign resp_err  = ((state_q == WR_RESP) && m_bvalid && (m_bresp != 2'b00)) ||
                     ((state_q == RD_DATA) && m_rvalid && (m_rresp != 2'b00));
  assign err_count = err_count_q;

  // Saturating count of non-OKAY responses; clear wins over increment.
  always_comb begin
    err_count_d = err_count_q;
    if (err_clr) begin
      err_count_d = '0;
    end else if (resp_err && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  // Error counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_count_q <= '0;
    else     err_count_q <= err_count_d;
  end
`endif

endmodule

// File: tb/tb_axil_master.sv
// Directed bench for axil_master: the bench plays the AXI slave and the
// local command/response user cycle by cycle. Inputs are driven and outputs
// sampled 1 ns after each rising edge.
module tb_axil_master;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] m_awaddr;
  logic [2:0]  m_awprot;
  logic        m_awvalid;
  logic        m_awready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wvalid;
  logic        m_wready;
  logic [1:0]  m_bresp;
  logic        m_bvalid;
  logic        m_bready;
  logic [31:0] m_araddr;
  logic [2:0]  m_arprot;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rvalid;
  logic        m_rready;
`ifdef AXIL_MASTER_ERR_CNT_EN
  logic [7:0]  err_count;
  logic        err_clr;
`endif

  int n_cmp;
  int n_fail;

  axil_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_wstrb (cmd_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_write (rsp_write),
    .rsp_rdata (rsp_rdata),
    .rsp_resp  (rsp_resp),
    .m_awaddr  (m_awaddr),
    .m_awprot  (m_awprot),
    .m_awvalid (m_awvalid),
    .m_awready (m_awready),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_wvalid  (m_wvalid),
    .m_wready  (m_wready),
    .m_bresp   (m_bresp),
    .m_bvalid  (m_bvalid),
    .m_bready  (m_bready),
    .m_araddr  (m_araddr),
    .m_arprot  (m_arprot),
    .m_arvalid (m_arvalid),
    .m_arready (m_arready),
    .m_rdata   (m_rdata),
    .m_rresp   (m_rresp),
    .m_rvalid  (m_rvalid),
    .m_rready  (m_rready)
`ifdef AXIL_MASTER_ERR_CNT_EN
    ,
    .err_count (err_count),
    .err_clr   (err_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    m_awready = 1'b0; m_wready = 1'b0; m_bresp = 2'b00; m_bvalid = 1'b0;
    m_arready = 1'b0; m_rdata = '0; m_rresp = 2'b00; m_rvalid = 1'b0;
`ifdef AXIL_MASTER_ERR_CNT_EN
    err_clr = 1'b0;
`endif

    // ---- reset state ----
    tick(); tick();
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_awvalid",   m_awvalid, 0);
    check("rst_wvalid",    m_wvalid, 0);
    check("rst_arvalid",   m_arvalid, 0);
    check("rst_bready",    m_bready, 0);
    check("rst_rready",    m_rready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_awaddr",    m_awaddr, 0);
    check("rst_wdata",     m_wdata, 0);
    check("rst_wstrb",     m_wstrb, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_resp",  rsp_resp, 0);
    check("rst_rsp_write", rsp_write, 0);
`ifdef AXIL_MASTER_ERR_CNT_EN
    check("rst_err_count", err_count, 0);
`endif
    rst = 1'b0;
    #1;
    check("idle_cmd_ready", cmd_ready, 1);

    // ---- write, zero-wait slave ----
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h8;
    cmd_wdata = 32'hDEADBEEF; cmd_wstrb = 4'hF;
    m_awready = 1'b1; m_wready = 1'b1;
    tick();                                   // cycle 0 edge: accept
    cmd_valid = 1'b0;
    check("wr_c1_awvalid", m_awvalid, 1);
    check("wr_c1_wvalid",  m_wvalid, 1);
    check("wr_c1_awaddr",  m_awaddr, 32'h8);
    check("wr_c1_wdata",   m_wdata, 32'hDEADBEEF);
    check("wr_c1_wstrb",   m_wstrb, 4'hF);
    check("wr_c1_awprot",  m_awprot, 0);
    check("wr_c1_cmd_ready", cmd_ready, 0);
    tick();                                   // cycle 1 edge: AW/W handshake
    check("wr_c2_awvalid", m_awvalid, 0);
    check("wr_c2_wvalid",  m_wvalid, 0);
    check("wr_c2_bready",  m_bready, 1);
    check("wr_c2_rsp_valid", rsp_valid, 0);
    m_bvalid = 1'b1; m_bresp = 2'b00;
    tick();                                   // cycle 2 edge: B captured
    m_bvalid = 1'b0;
    check("wr_c3_rsp_valid", rsp_valid, 1);
    check("wr_c3_rsp_write", rsp_write, 1);
    check("wr_c3_rsp_resp",  rsp_resp, 2'b00);
    check("wr_c3_rsp_rdata", rsp_rdata, 0);
    check("wr_c3_bready",    m_bready, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("wr_done_rsp_valid", rsp_valid, 0);
    check("wr_done_cmd_ready", cmd_ready, 1);

    // ---- read, zero-wait slave ----
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h8;
    m_arready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("rd_c1_arvalid", m_arvalid, 1);
    check("rd_c1_araddr",  m_araddr, 32'h8);
    check("rd_c1_arprot",  m_arprot, 0);
    check("rd_c1_awvalid", m_awvalid, 0);
    tick();
    check("rd_c2_arvalid", m_arvalid, 0);
    check("rd_c2_rready",  m_rready, 1);
    m_rvalid = 1'b1; m_rdata = 32'hDEADBEEF; m_rresp = 2'b00;
    tick();
    m_rvalid = 1'b0; m_rdata = 32'h0;
    check("rd_c3_rsp_valid", rsp_valid, 1);
    check("rd_c3_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    check("rd_c3_rsp_write", rsp_write, 0);
    check("rd_c3_rsp_resp",  rsp_resp, 2'b00);
    check("rd_c3_rready",    m_rready, 0);

    // ---- response backpressure with a waiting command ----
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h44;
    m_arready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
      check("bp_rsp_resp",  rsp_resp, 2'b00);
      check("bp_rsp_write", rsp_write, 0);
      check("bp_cmd_ready", cmd_ready, 0);
      check("bp_arvalid",   m_arvalid, 0);
    end
    rsp_ready = 1'b1;
    tick();                                   // rsp handshake
    rsp_ready = 1'b0;
    check("bp_rel_rsp_valid", rsp_valid, 0);
    check("bp_rel_cmd_ready", cmd_ready, 1);
    check("bp_rel_arvalid",   m_arvalid, 0);
    tick();                                   // waiting command accepted now
    cmd_valid = 1'b0;
    check("bp_acc_arvalid", m_arvalid, 1);
    check("bp_acc_araddr",  m_araddr, 32'h44);
    tick();                                   // slave stalls AR one cycle
    check("bp_stall_arvalid", m_arvalid, 1);
    check("bp_stall_araddr",  m_araddr, 32'h44);
    m_arready = 1'b1;
    tick();
    check("err_rready", m_rready, 1);
    m_rvalid = 1'b1; m_rdata = 32'h12345678; m_rresp = 2'b10;
    tick();
    m_rvalid = 1'b0; m_rresp = 2'b00;
    check("err_rsp_valid", rsp_valid, 1);
    check("err_rsp_resp",  rsp_resp, 2'b10);
    check("err_rsp_rdata", rsp_rdata, 32'h12345678);
`ifdef AXIL_MASTER_ERR_CNT_EN
    check("err_count_1", err_count, 1);
`endif
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // ---- skewed write: AW immediate, W three cycles late ----
    m_awready = 1'b1; m_wready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h14;
    cmd_wdata = 32'hA5A55A5A; cmd_wstrb = 4'h3;
    tick();                                   // accept
    cmd_valid = 1'b0; cmd_wdata = 32'h0; cmd_wstrb = 4'h0;
    check("sk_c1_awvalid", m_awvalid, 1);
    check("sk_c1_wvalid",  m_wvalid, 1);
    tick();                                   // AW handshake only
    check("sk_c2_awvalid", m_awvalid, 0);
    check("sk_c2_wvalid",  m_wvalid, 1);
    check("sk_c2_wdata",   m_wdata, 32'hA5A55A5A);
    check("sk_c2_wstrb",   m_wstrb, 4'h3);
    check("sk_c2_bready",  m_bready, 0);
    tick();
    check("sk_c3_wvalid",  m_wvalid, 1);
    check("sk_c3_wdata",   m_wdata, 32'hA5A55A5A);
    check("sk_c3_wstrb",   m_wstrb, 4'h3);
    check("sk_c3_awvalid", m_awvalid, 0);
    m_wready = 1'b1;
    tick();                                   // W handshake
    check("sk_c4_wvalid", m_wvalid, 0);
    check("sk_c4_bready", m_bready, 1);
    m_bvalid = 1'b1; m_bresp = 2'b01;         // held high two cycles
    tick();
    check("sk_c5_rsp_valid", rsp_valid, 1);
    check("sk_c5_rsp_resp",  rsp_resp, 2'b01);
    check("sk_c5_rsp_write", rsp_write, 1);
    check("sk_c5_bready",    m_bready, 0);
`ifdef AXIL_MASTER_ERR_CNT_EN
    check("err_count_2", err_count, 2);
`endif
    tick();
    check("sk_c6_bready",    m_bready, 0);
    check("sk_c6_rsp_valid", rsp_valid, 1);
    m_bvalid = 1'b0; m_bresp = 2'b00;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("sk_done_rsp_valid", rsp_valid, 0);
    tick();
    check("sk_single_b_rsp_valid", rsp_valid, 0);
    check("sk_single_b_cmd_ready", cmd_ready, 1);
`ifdef AXIL_MASTER_ERR_CNT_EN
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_count_clr", err_count, 0);
`endif

    // ---- reset while AR is pending ----
    m_arready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h20;
    tick();
    cmd_valid = 1'b0;
    check("rr_arvalid_pre", m_arvalid, 1);
    check("rr_araddr_pre",  m_araddr, 32'h20);
    rst = 1'b1;
    #1;
    check("rr_arvalid_rst",  m_arvalid, 0);
    check("rr_araddr_rst",   m_araddr, 0);
    check("rr_cmd_ready_rst", cmd_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    check("rr_cmd_ready_after", cmd_ready, 1);
    check("rr_rsp_valid_after", rsp_valid, 0);
    m_arready = 1'b1;
    tick();
    check("rr_no_rsp",     rsp_valid, 0);
    check("rr_no_arvalid", m_arvalid, 0);

    // ---- spurious B/R while idle ----
    m_bvalid = 1'b1; m_bresp = 2'b10;
    m_rvalid = 1'b1; m_rresp = 2'b11; m_rdata = 32'hFFFF0000;
    #1;
    check("sp_bready", m_bready, 0);
    check("sp_rready", m_rready, 0);
    tick();
    check("sp_cmd_ready", cmd_ready, 1);
    check("sp_rsp_valid", rsp_valid, 0);
    check("sp_bready_2",  m_bready, 0);
`ifdef AXIL_MASTER_ERR_CNT_EN
    check("sp_err_count", err_count, 0);
`endif
    m_bvalid = 1'b0; m_bresp = 2'b00;
    m_rvalid = 1'b0; m_rresp = 2'b00; m_rdata = 32'h0;

    // ---- normal read after spurious activity ----
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h31;
    tick();
    cmd_valid = 1'b0;
    check("fr_arvalid", m_arvalid, 1);
    check("fr_araddr_unaligned", m_araddr, 32'h31);
    tick();
    check("fr_rready", m_rready, 1);
    m_rvalid = 1'b1; m_rdata = 32'hCAFEF00D; m_rresp = 2'b00;
    tick();
    m_rvalid = 1'b0;
    check("fr_rsp_valid", rsp_valid, 1);
    check("fr_rsp_rdata", rsp_rdata, 32'hCAFEF00D);
    check("fr_rsp_resp",  rsp_resp, 2'b00);
    check("fr_rsp_write", rsp_write, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("fr_done_cmd_ready", cmd_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_master.md
Name: axil_master

Overview:
- AXI4-Lite initiator that converts single-beat commands from local control logic into AXI4-Lite read or write transactions.
- Returns the response data and status on a simple valid/ready response port.
- Drives the AXI4-Lite slave that fronts the team's register-file storage; it is the bus-side counterpart used by test sequencers and on-chip controllers.
- One transaction is in flight at a time.

Parameters:
- ADDR_WIDTH, 32, width of the AXI address and the command address.
- DATA_WIDTH, 32, AXI data width; fixed at 32 in this revision; WSTRB width is DATA_WIDTH/8.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset; one clock; reset is asynchronous and active-high.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  block can accept a command; high only in IDLE with rst low.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  ADDR_WIDTH  byte address.
- cmd_wdata  input  DATA_WIDTH  write data.
- cmd_wstrb  input  DATA_WIDTH/8  write byte strobes.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  response consumed.
- rsp_write  output  1  response belongs to a write.
- rsp_rdata  output  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  output  2  BRESP or RRESP as received.
- m_awaddr, m_awprot, m_awvalid, m_awready: AXI AW channel; m_awprot is constant 3'b000.
- m_wdata, m_wstrb, m_wvalid, m_wready: AXI W channel.
- m_bresp, m_bvalid, m_bready: AXI B channel.
- m_araddr, m_arprot, m_arvalid, m_arready: AXI AR channel; m_arprot is constant 3'b000.
- m_rdata, m_rresp, m_rvalid, m_rready: AXI R channel.

Behaviour:
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RESP.
- Reset values:
  - state IDLE.
  - All *valid and *ready outputs 0.
  - All address, data and strobe outputs 0.
  - rsp_rdata 0, rsp_resp 2'b00, rsp_write 0.
- Command accept:
  - A command is accepted when cmd_valid & cmd_ready.
  - All cmd_* fields are latched on that edge.
  - Write goes to WR_REQ; read goes to RD_REQ.
- WR_REQ:
  - m_awvalid and m_wvalid both assert in the cycle after accept.
  - Each drops independently on its own handshake (valid & ready).
  - Either order, or the same cycle, is legal.
  - Leave WR_REQ when both handshakes are done.
- WR_RESP:
  - m_bready=1.
  - On m_bvalid, capture m_bresp into rsp_resp, set rsp_write=1, set rsp_rdata=0, go to RESP.
- RD_REQ:
  - m_arvalid=1 until m_arready, then go to RD_DATA.
- RD_DATA:
  - m_rready=1.
  - On m_rvalid, capture m_rdata and m_rresp, set rsp_write=0, go to RESP.
- RESP:
  - rsp_valid=1, with payload stable until rsp_ready.
  - On rsp_valid & rsp_ready, return to IDLE.
  - The next command can be accepted one cycle later.
- AXI rules:
  - Once asserted, a valid is never withdrawn before its handshake.
  - Address, data and strobe outputs are stable while their valid is high.
  - No combinational path from any *ready input to any *valid output.
- Latency with a zero-wait slave (B/R returned the cycle after the address/data handshake):
  - accept at cycle 0
  - AW/W or AR handshake at cycle 1
  - B or R captured at cycle 2
  - rsp_valid at cycle 3
- Spurious m_bvalid or m_rvalid outside WR_RESP/RD_DATA: ready stays low, no state change.
- rsp_resp is passed through unmodified (OKAY, EXOKAY, SLVERR, DECERR); no retry.
- Reset mid-transaction: all outputs return to reset values immediately, state goes to IDLE, no response is produced for the aborted command.
- Address is passed through unaligned; no alignment check.

Optional Feature:
- Macro: AXIL_MASTER_ERR_CNT_EN.
- When defined:
  - Adds output err_count [7:0].
  - Increments by 1 on each B or R capture with resp != 2'b00; saturates at 8'hFF.
  - Reset value 0.
  - Adds input err_clr; when high, clears err_count to 0, taking precedence over increment in the same cycle.
- When undefined: neither port exists and no counter logic is built.

Test Plan:
- Write, zero-wait slave: cmd addr 0x8, wdata 0xDEADBEEF, wstrb 4'hF -> AW/W observed at cycle 1 with awaddr 0x8; rsp_valid at cycle 3 with rsp_write=1, rsp_resp 2'b00, rsp_rdata 0.
- Read: cmd read 0x8, slave returns 0xDEADBEEF/OKAY -> rsp_rdata 0xDEADBEEF, rsp_write=0, rsp_resp 2'b00.
- Skewed write handshake: m_wready 3 cycles late, m_awready immediate -> m_awvalid drops after 1 cycle; m_wvalid held with wdata and wstrb stable until the handshake; exactly one B accepted.
- Backpressure: rsp_ready held low 5 cycles -> rsp_valid and payload held constant; cmd_ready stays 0; new command accepted only after the rsp handshake.
- Error and reset: slave returns RRESP 2'b10 -> rsp_resp 2'b10 (err_count=1 with AXIL_MASTER_ERR_CNT_EN); rst asserted while m_arvalid=1 -> m_arvalid=0 immediately, no rsp_valid, cmd_ready=1 after rst drops.
- Spurious channel activity: m_bvalid pulse while IDLE -> m_bready stays 0, state unchanged; a following read completes normally.
